hash_table: RTL and testbench

Pipelined exact-match key/value store: one operation (search, insert, delete) accepted per clock, result returned a fixed number of cycles later. Storage is split into NUM_PES banks of set-associative buckets; a multiplicative hash of the key selects bank and bucket. It sits behind a request/response stream interface with no backpressure.

---
 rtl/hash_table_if.sv | 39 +++
 rtl/hash_table.sv | 242 ++++++++++++++++++++++++
 tb/tb_hash_table.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hash_table_if.sv
// hash_table_if
// Request/response stream bundle for the hash_table key/value store.
// There is no backpressure: a request is taken on every rising edge where
// in_input_valid is high, and a response appears as a one-cycle strobe.
//
// Signals
//   in_input_valid   request strobe
//   in_opcode        0 NOP, 1 SEARCH, 2 INSERT, 3 DELETE, others illegal
//   in_key           lookup key
//   in_wr_data       value for INSERT
//   out_output_valid response strobe
//   out_val_out      value on SEARCH hit, else 0
//   out_rescode      result code
//
// Modports
//   master  drives requests, receives responses (testbench / upstream)
//   slave   receives requests, drives responses (hash_table)
interface hash_table_if #(
  parameter int KEY_WIDTH = 32,
  parameter int VAL_WIDTH = 32
);
  logic                 in_input_valid;
  logic [3:0]           in_opcode;
  logic [KEY_WIDTH-1:0] in_key;
  logic [VAL_WIDTH-1:0] in_wr_data;
  logic                 out_output_valid;
  logic [VAL_WIDTH-1:0] out_val_out;
  logic [4:0]           out_rescode;

  modport master (
    output in_input_valid, in_opcode, in_key, in_wr_data,
    input  out_output_valid, out_val_out, out_rescode
  );

  modport slave (
    input  in_input_valid, in_opcode, in_key, in_wr_data,
    output out_output_valid, out_val_out, out_rescode
  );
endinterface

// File: rtl/hash_table.sv
// hash_table
// Pipelined exact-match key/value store. One SEARCH/INSERT/DELETE is accepted
// per clock and answered exactly three clocks later, in order. Storage is
// NUM_PES banks of NUM_ENTRIES_PER_HASH_TABLE set-associative buckets with
// NUM_SLOTS_PER_ENTRY slots each; a multiplicative hash of the key picks bank
// (low hash bits) and bucket (next bits). Banks are stored as one flat array
// addressed by {bucket, bank}, which is just the low hash bits.
//
// Ports
//   clock  rising-edge clock
//   reset  synchronous, active-high; clears every valid bit, flushes the
//          pipeline and zeroes the outputs
//   bus    hash_table_if.slave request/response stream
//
// Optional feature macro: HASH_TABLE_UPDATE_EN
//   defined     INSERT of an existing key overwrites its value (code 4)
//   undefined   INSERT of an existing key leaves the value untouched and
//               still answers code 4, read as "duplicate"
module hash_table #(
  parameter int NUM_PES                    = 4,
  parameter int NUM_ENTRIES_PER_HASH_TABLE = 1024,
  parameter int NUM_SLOTS_PER_ENTRY        = 4,
  parameter int KEY_WIDTH                  = 32,
  parameter int VAL_WIDTH                  = 32
) (
  input logic          clock,
  input logic          reset,
  hash_table_if.slave  bus
);

  localparam int DEPTH     = NUM_PES * NUM_ENTRIES_PER_HASH_TABLE;
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam int SLOTS     = NUM_SLOTS_PER_ENTRY;
  localparam int SLOT_BITS = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [31:0] HASH_MULT = 32'h9E3779B1;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_SEARCH = 4'd1;
  localparam logic [3:0] OP_INSERT = 4'd2;
  localparam logic [3:0] OP_DELETE = 4'd3;

  typedef enum logic [4:0] {
    RES_NONE          = 5'd0,
    RES_SEARCH_HIT    = 5'd1,
    RES_SEARCH_MISS   = 5'd2,
    RES_INSERT_OK     = 5'd3,
    RES_INSERT_UPDATE = 5'd4,
    RES_INSERT_FULL   = 5'd5,
    RES_DELETE_OK     = 5'd6,
    RES_DELETE_MISS   = 5'd7,
    RES_BAD_OP        = 5'd8
  } rescode_e;

  // Storage: valid bits are flops so reset can clear the whole table at once.
  logic [DEPTH-1:0][SLOTS-1:0] validMem_q;
  logic [KEY_WIDTH-1:0]        keyMem_q [DEPTH][SLOTS];
  logic [VAL_WIDTH-1:0]        valMem_q [DEPTH][SLOTS];

  // S0: registered request plus bucket index
  logic                 s0Valid_d, s0Valid_q;
  logic [3:0]           s0Op_q;
  logic [KEY_WIDTH-1:0] s0Key_q;
  logic [VAL_WIDTH-1:0] s0Data_q;
  logic [IDX_BITS-1:0]  s0Idx_d, s0Idx_q;

  // S1: request plus the bucket contents it will operate on
  logic                 s1Valid_q;
  logic [3:0]           s1Op_q;
  logic [KEY_WIDTH-1:0] s1Key_q;
  logic [VAL_WIDTH-1:0] s1Data_q;
  logic [IDX_BITS-1:0]  s1Idx_q;
  logic [SLOTS-1:0]     s1BktValid_d, s1BktValid_q;
  logic [KEY_WIDTH-1:0] s1BktKey_d [SLOTS];
  logic [KEY_WIDTH-1:0] s1BktKey_q [SLOTS];
  logic [VAL_WIDTH-1:0] s1BktVal_d [SLOTS];
  logic [VAL_WIDTH-1:0] s1BktVal_q [SLOTS];

  // S2: compare result, updated bucket image, result registers
  logic                 hit, freeFound, wrEn, fwd;
  logic [SLOT_BITS-1:0] hitIdx, freeIdx;
  logic [SLOTS-1:0]     newValid;
  logic [KEY_WIDTH-1:0] newKey [SLOTS];
  logic [VAL_WIDTH-1:0] newVal [SLOTS];
  rescode_e             s2Res_d, s2Res_q;
  logic [VAL_WIDTH-1:0] s2Val_d, s2Val_q;
  logic                 s2Valid_q;

  // Output registers
  logic                 outValid_q;
  rescode_e             outRes_q;
  logic [VAL_WIDTH-1:0] outVal_q;

  // Hash the incoming key. Only the low IDX_BITS of the 32-bit product are
  // needed, and those depend only on the low bits of the operands.
  always_comb begin
    s0Valid_d = bus.in_input_valid && (bus.in_opcode != OP_NOP);
    s0Idx_d   = IDX_BITS'(32'(bus.in_key) * HASH_MULT);
  end

  // Bucket read. If the op currently in S2 is writing the very bucket this op
  // is about to load, take S2's updated image instead of the stale array so
  // back-to-back ops on one bucket see each other's effects.
  always_comb begin
    fwd          = wrEn && (s0Idx_q == s1Idx_q);
    s1BktValid_d = fwd ? newValid : validMem_q[s0Idx_q];
    for (int s = 0; s < SLOTS; s++) begin
      s1BktKey_d[SLOT_BITS'(s)] = fwd ? newKey[SLOT_BITS'(s)]
                                      : keyMem_q[s0Idx_q][SLOT_BITS'(s)];
      s1BktVal_d[SLOT_BITS'(s)] = fwd ? newVal[SLOT_BITS'(s)]
                                      : valMem_q[s0Idx_q][SLOT_BITS'(s)];
    end
  end

  // Compare and decide. Scanning high-to-low leaves the lowest free slot in
  // freeIdx; keys are unique per bucket so at most one slot can hit.
  always_comb begin
    hit       = 1'b0;
    hitIdx    = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (s1BktValid_q[SLOT_BITS'(s)] && (s1BktKey_q[SLOT_BITS'(s)] == s1Key_q)) begin
        hit    = 1'b1;
        hitIdx = SLOT_BITS'(s);
      end
      if (!s1BktValid_q[SLOT_BITS'(s)]) begin
        freeFound = 1'b1;
        freeIdx   = SLOT_BITS'(s);
      end
    end

    newValid = s1BktValid_q;
    newKey   = s1BktKey_q;
    newVal   = s1BktVal_q;
    wrEn     = 1'b0;
    s2Res_d  = RES_NONE;
    s2Val_d  = '0;

    if (s1Valid_q) begin
      case (s1Op_q)
        OP_SEARCH: begin
          if (hit) begin
            s2Res_d = RES_SEARCH_HIT;
            s2Val_d = s1BktVal_q[hitIdx];
          end else begin
            s2Res_d = RES_SEARCH_MISS;
          end
        end
        OP_INSERT: begin
          if (hit) begin
            s2Res_d = RES_INSERT_UPDATE;
`ifdef HASH_TABLE_UPDATE_EN
            newVal[hitIdx] = s1Data_q;
            wrEn           = 1'b1;
`endif
          end else if (freeFound) begin
            newValid[freeIdx] = 1'b1;
            newKey[freeIdx]   = s1Key_q;
            newVal[freeIdx]   = s1Data_q;
            wrEn              = 1'b1;
            s2Res_d           = RES_INSERT_OK;
          end else begin
            s2Res_d = RES_INSERT_FULL;
          end
        end
        OP_DELETE: begin
          if (hit) begin
            newValid[hitIdx] = 1'b0;
            wrEn             = 1'b1;
            s2Res_d          = RES_DELETE_OK;
          end else begin
            s2Res_d = RES_DELETE_MISS;
          end
        end
        default: s2Res_d = RES_BAD_OP;
      endcase
    end
  end

  // Valid bits: cleared wholesale on reset, otherwise written back from S2.
  always_ff @(posedge clock) begin
    if (reset) begin
      validMem_q <= '0;
    end else if (wrEn) begin
      validMem_q[s1Idx_q] <= newValid;
    end
  end

  // Key/value arrays carry no reset; a slot's contents only matter when valid.
  always_ff @(posedge clock) begin
    if (wrEn && !reset) begin
      for (int s = 0; s < SLOTS; s++) begin
        keyMem_q[s1Idx_q][SLOT_BITS'(s)] <= newKey[SLOT_BITS'(s)];
        valMem_q[s1Idx_q][SLOT_BITS'(s)] <= newVal[SLOT_BITS'(s)];
      end
    end
  end

  // Pipeline control and result path. Reset drops every in-flight op.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0Valid_q  <= 1'b0;
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Res_q    <= RES_NONE;
      s2Val_q    <= '0;
      outValid_q <= 1'b0;
      outRes_q   <= RES_NONE;
      outVal_q   <= '0;
    end else begin
      s0Valid_q  <= s0Valid_d;
      s1Valid_q  <= s0Valid_q;
      s2Valid_q  <= s1Valid_q;
      s2Res_q    <= s2Res_d;
      s2Val_q    <= s2Val_d;
      outValid_q <= s2Valid_q;
      outRes_q   <= s2Res_q;
      outVal_q   <= s2Val_q;
    end
  end

  // Pipeline payload; only meaningful alongside the matching valid bit.
  always_ff @(posedge clock) begin
    s0Op_q       <= bus.in_opcode;
    s0Key_q      <= bus.in_key;
    s0Data_q     <= bus.in_wr_data;
    s0Idx_q      <= s0Idx_d;
    s1Op_q       <= s0Op_q;
    s1Key_q      <= s0Key_q;
    s1Data_q     <= s0Data_q;
    s1Idx_q      <= s0Idx_q;
    s1BktValid_q <= s1BktValid_d;
    s1BktKey_q   <= s1BktKey_d;
    s1BktVal_q   <= s1BktVal_d;
  end

  assign bus.out_output_valid = outValid_q;
  assign bus.out_rescode      = outRes_q;
  assign bus.out_val_out      = outVal_q;

endmodule

// File: tb/tb_hash_table.sv
// tb_hash_table
// Directed bench for hash_table. Requests are driven one per cycle; each one
// queues its expected response, and the output is compared every cycle
// against the entry queued three cycles earlier, so latency, ordering and
// the absence of spurious responses are all checked.
module tb_hash_table;

  localparam int KW = 32;
  localparam int VW = 32;

  localparam int OP_NOP = 0;
  localparam int OP_SRCH = 1;
  localparam int OP_INS = 2;
  localparam int OP_DEL = 3;

`ifdef HASH_TABLE_UPDATE_EN
  localparam int KEY10_VAL = 200;
  localparam int KEY4099_VAL = 66;
`else
  localparam int KEY10_VAL = 100;
  localparam int KEY4099_VAL = 22;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  hash_table_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW)) bus ();

  hash_table #(
    .NUM_PES                   (4),
    .NUM_ENTRIES_PER_HASH_TABLE(1024),
    .NUM_SLOTS_PER_ENTRY       (4),
    .KEY_WIDTH                 (KW),
    .VAL_WIDTH                 (VW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        v;
    logic [4:0]  res;
    logic [31:0] val;
    string       tag;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] key;
    logic [31:0] data;
    exp_t        exp;
  } vec_t;

  exp_t expQ[$];
  vec_t tbl[$];
  int   passCount = 0;
  int   checkCount = 0;

  function automatic vec_t mk(input int valid, input int op, input int key, input int data,
                              input int ev, input int res, input int val, input string tag);
    vec_t r;
    r.valid   = (valid != 0);
    r.op      = 4'(op);
    r.key     = 32'(key);
    r.data    = 32'(data);
    r.exp.v   = (ev != 0);
    r.exp.res = 5'(res);
    r.exp.val = 32'(val);
    r.exp.tag = tag;
    return r;
  endfunction

  function automatic vec_t idleVec();
    return mk(0, OP_NOP, 0, 0, 0, 0, 0, "idle");
  endfunction

  // Compare the current response against one expectation.
  task automatic checkOutput(input exp_t e);
    checkCount++;
    if (bus.out_output_valid === e.v && bus.out_rescode === e.res && bus.out_val_out === e.val) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got valid=%0b code=%0d val=%0d, expected valid=%0b code=%0d val=%0d",
               e.tag, bus.out_output_valid, bus.out_rescode, bus.out_val_out, e.v, e.res, e.val);
    end
  endtask

  // Drive one request for one cycle, then check the response due this cycle.
  task automatic applyStimulus(input vec_t v);
    bus.in_input_valid = v.valid;
    bus.in_opcode      = v.op;
    bus.in_key         = v.key;
    bus.in_wr_data     = v.data;
    expQ.push_back(v.exp);
    @(posedge clock);
    @(negedge clock);
    checkOutput(expQ.pop_front());
  endtask

  // Hold reset for n cycles with outputs expected at zero, then reseed the
  // expectation pipeline with three idle slots.
  task automatic doReset(input int n);
    exp_t e;
    e = idleVec().exp;
    e.tag = "reset";
    reset              = 1'b1;
    bus.in_input_valid = 1'b0;
    bus.in_opcode      = 4'd0;
    bus.in_key         = '0;
    bus.in_wr_data     = '0;
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput(e);
    end
    reset = 1'b0;
    expQ.delete();
    repeat (3) expQ.push_back(idleVec().exp);
  endtask

  initial begin
    // Keys 3, 4099, 8195, 12291, 16387 agree mod 4096, so their hashes agree
    // in the low 12 bits: same bank and bucket.
    tbl.push_back(mk(1, OP_SRCH, 11,    0,  1, 2, 0,  "srch11_empty"));
    tbl.push_back(mk(1, OP_INS,  3,     11, 1, 3, 0,  "ins_c0"));
    tbl.push_back(mk(1, OP_INS,  4099,  22, 1, 3, 0,  "ins_c1"));
    tbl.push_back(mk(1, OP_INS,  8195,  33, 1, 3, 0,  "ins_c2"));
    tbl.push_back(mk(1, OP_INS,  12291, 44, 1, 3, 0,  "ins_c3"));
    tbl.push_back(mk(1, OP_INS,  16387, 55, 1, 5, 0,  "ins_c4_full"));
    tbl.push_back(mk(1, OP_SRCH, 16387, 0,  1, 2, 0,  "srch_c4_miss"));
    tbl.push_back(mk(1, OP_SRCH, 8195,  0,  1, 1, 33, "srch_c2_hit"));
    tbl.push_back(mk(1, OP_INS,  7,     5,  1, 3, 0,  "ins7"));
    tbl.push_back(mk(1, OP_SRCH, 7,     0,  1, 1, 5,  "srch7_hit"));
    tbl.push_back(mk(1, OP_DEL,  7,     0,  1, 6, 0,  "del7"));
    tbl.push_back(mk(1, OP_SRCH, 7,     0,  1, 2, 0,  "srch7_miss"));
    tbl.push_back(mk(1, OP_DEL,  7,     0,  1, 7, 0,  "del7_miss"));
    tbl.push_back(mk(1, OP_INS,  10,    200, 1, 4, 0, "ins10_again"));
    tbl.push_back(mk(1, OP_SRCH, 10,    0,  1, 1, KEY10_VAL, "srch10_after"));
    tbl.push_back(mk(1, 15,      10,    9,  1, 8, 0,  "badop_f"));
    tbl.push_back(mk(1, OP_NOP,  10,    9,  0, 0, 0,  "nop_valid"));
    tbl.push_back(mk(1, 5,       10,    9,  1, 8, 0,  "badop_5"));
    tbl.push_back(mk(1, OP_SRCH, 10,    0,  1, 1, KEY10_VAL, "srch10_kept"));
    tbl.push_back(mk(1, OP_DEL,  3,     0,  1, 6, 0,  "del_c0"));
    tbl.push_back(mk(1, OP_INS,  16387, 55, 1, 3, 0,  "ins_c4_slot0"));
    tbl.push_back(mk(1, OP_SRCH, 16387, 0,  1, 1, 55, "srch_c4_hit"));
    tbl.push_back(mk(0, OP_INS,  99,    1,  0, 0, 0,  "invalid_ins"));
    tbl.push_back(mk(1, OP_SRCH, 99,    0,  1, 2, 0,  "srch99_miss"));
    tbl.push_back(mk(1, OP_INS,  4099,  66, 1, 4, 0,  "ins_c1_again"));
    tbl.push_back(mk(1, OP_SRCH, 4099,  0,  1, 1, KEY4099_VAL, "srch_c1"));

    doReset(2);

    // Single insert/search separated by long idle gaps.
    repeat (10) applyStimulus(idleVec());
    applyStimulus(mk(1, OP_INS, 10, 100, 1, 3, 0, "ins10"));
    repeat (50) applyStimulus(idleVec());
    applyStimulus(mk(1, OP_SRCH, 10, 0, 1, 1, 100, "srch10"));
    repeat (3) applyStimulus(idleVec());

    // Back-to-back vector table.
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);
    repeat (3) applyStimulus(idleVec());

    // Reset with two inserts still in flight: neither may respond or land.
    applyStimulus(mk(1, OP_INS, 20, 1, 1, 3, 0, "ins20_dropped"));
    applyStimulus(mk(1, OP_INS, 21, 2, 1, 3, 0, "ins21_dropped"));
    doReset(2);
    applyStimulus(mk(1, OP_SRCH, 20,    0, 1, 2, 0, "srch20_post_rst"));
    applyStimulus(mk(1, OP_SRCH, 21,    0, 1, 2, 0, "srch21_post_rst"));
    applyStimulus(mk(1, OP_SRCH, 10,    0, 1, 2, 0, "srch10_post_rst"));
    applyStimulus(mk(1, OP_SRCH, 16387, 0, 1, 2, 0, "srch_c4_post_rst"));
    repeat (4) applyStimulus(idleVec());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
